grey_decade_chain: RTL and testbench
====================================

GREY_DECADE_CHAIN -- requirements
Module: grey_decade_chain

Interface
REQ-001 Parameter pDIGITS, default 4, number of cascaded decade digits, legal range 1..8.
REQ-002 Parameter pINIT, default 0, unsigned decimal reset value; values at or above 10**pDIGITS are reduced modulo 10**pDIGITS.
REQ-003 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_en  in  1  count step request, one step per cycle while high.
REQ-006 i_dn  in  1  direction: 0 = up, 1 = down; sampled only with i_en.
REQ-007 i_load  in  1  synchronous load strobe.
REQ-008 i_load_bcd  in  4*pDIGITS  load value, packed BCD, digit 0 in bits [3:0].
REQ-009 o_cnt  out  5*pDIGITS  registered 5-bit unit-distance code per digit, digit 0 in bits [4:0].
REQ-010 o_bcd  out  4*pDIGITS  BCD decode of o_cnt, combinational from the registers, no added latency.
REQ-011 o_roll  out  1  one-cycle wrap pulse.
REQ-012 o_zero  out  1  high while every digit holds code 0.
REQ-013 o_err  out  1  one-cycle illegal-code or illegal-load pulse.

Function
REQ-014 The digit code table shall be: 0=11000, 1=11001, 2=10001, 3=10011, 4=00011, 5=00111, 6=00110, 7=01110, 8=01100, 9=11100; consecutive codes, including 9->0, differ in exactly one bit.
REQ-015 Priority per cycle shall be i_rst > i_load > i_en; the lower-priority request is discarded without being queued.
REQ-016 With i_en=1, i_dn=0: digit 0 advances one code; digit k advances only when all digits below k hold 9; a digit at 9 that advances goes to 0.
REQ-017 With i_en=1, i_dn=1: digit 0 retreats one code; digit k retreats only when all digits below k hold 0; a digit at 0 that retreats goes to 9.
REQ-018 The ripple carry/borrow shall be resolved within one cycle: the whole chain updates on the same edge, so o_cnt never shows an intermediate value.
REQ-019 o_roll shall be high for exactly the one cycle in which o_cnt first shows the wrapped value: all 0 after an up-step from all 9, or all 9 after a down-step from all 0.
REQ-020 o_roll shall stay low after a load or reset, even when the loaded value is all 0 or all 9.
REQ-021 On i_load, each digit takes the code of its BCD nibble; a nibble above 9 loads code 0 for that digit, and o_err pulses high in the next cycle.
REQ-022 Every cycle, any digit register holding a code outside the table is replaced with code 0 on the next edge, and o_err pulses for that cycle. This check takes precedence over i_en for that digit; the carry from it is computed as if it held 0.
REQ-023 Idle (i_en=0, i_load=0) shall hold all state unchanged; o_roll and o_err shall be low.
REQ-024 o_zero shall be combinational from the registers and equal to (o_bcd == 0).

Reset
REQ-025 While i_rst is high at a clock edge, every digit shall load the code of its pINIT decimal digit, and o_roll and o_err shall be 0.
REQ-026 Reset asserted mid-count shall take effect on that edge; a coincident i_load or i_en shall be ignored.
REQ-027 The first edge after i_rst deasserts shall honour i_load or i_en normally, with no dead cycle.

Structure
REQ-028 Package grey_pkg shall hold the ten code constants and the encode (BCD to code), decode (code to BCD) and legality functions.
REQ-029 One sub-module, grey_digit, shall implement a single digit: code register, up/down next-state, carry/borrow in and out, load, illegal-code scrub. The top shall instantiate pDIGITS copies via generate and own o_roll and o_err.

Verification (pDIGITS=2 unless stated)
REQ-030 Reset with pINIT=37 -> o_bcd=0x37, o_cnt={10011,01110}; o_roll=0, o_err=0.
REQ-031 From 98, i_en=1, i_dn=0 for 2 cycles -> o_bcd 99 then 00; o_roll high only in the 00 cycle; each digit changes at most 1 bit per step.
REQ-032 From 00, i_dn=1, one step -> o_bcd=99 and o_roll pulses; next down-step -> 98 and o_roll low.
REQ-033 i_load=1, i_en=1, i_load_bcd=0x5C -> o_bcd=0x50 next cycle and o_err pulses once; the count step is ignored.
REQ-034 Force digit 1 to 10101 at 42 with i_en=1 -> next cycle o_bcd=03, o_err pulses once, then counting resumes.
REQ-035 pDIGITS=8, pINIT=99999999, one up-step -> o_bcd all 0, o_zero=1, o_roll pulses; i_rst asserted the same cycle instead -> value stays 99999999.

Source files
------------

// File: rtl/grey_pkg.sv
// Unit-distance decade code shared by the digit cells and the chain top:
// code constants plus encode/decode/legality helpers.
package grey_pkg;

  localparam logic [4:0] cCode0 = 5'b11000;
  localparam logic [4:0] cCode1 = 5'b11001;
  localparam logic [4:0] cCode2 = 5'b10001;
  localparam logic [4:0] cCode3 = 5'b10011;
  localparam logic [4:0] cCode4 = 5'b00011;
  localparam logic [4:0] cCode5 = 5'b00111;
  localparam logic [4:0] cCode6 = 5'b00110;
  localparam logic [4:0] cCode7 = 5'b01110;
  localparam logic [4:0] cCode8 = 5'b01100;
  localparam logic [4:0] cCode9 = 5'b11100;

  // Nibbles above 9 map to code 0 so a bad load lands on a legal value.
  function automatic logic [4:0] encode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return cCode0;
      4'd1:    return cCode1;
      4'd2:    return cCode2;
      4'd3:    return cCode3;
      4'd4:    return cCode4;
      4'd5:    return cCode5;
      4'd6:    return cCode6;
      4'd7:    return cCode7;
      4'd8:    return cCode8;
      4'd9:    return cCode9;
      default: return cCode0;
    endcase
  endfunction

  // Illegal codes decode as 0, which is also how the carry chain treats them.
  function automatic logic [3:0] decode(input logic [4:0] code);
    case (code)
      cCode0:  return 4'd0;
      cCode1:  return 4'd1;
      cCode2:  return 4'd2;
      cCode3:  return 4'd3;
      cCode4:  return 4'd4;
      cCode5:  return 4'd5;
      cCode6:  return 4'd6;
      cCode7:  return 4'd7;
      cCode8:  return 4'd8;
      cCode9:  return 4'd9;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic isLegal(input logic [4:0] code);
    case (code)
      cCode0, cCode1, cCode2, cCode3, cCode4,
      cCode5, cCode6, cCode7, cCode8, cCode9: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/grey_digit.sv
// One decade digit: code register with reset, load, illegal-code scrub and
// carry-qualified up/down stepping.
module grey_digit
  import grey_pkg::*;
#(
  parameter logic [3:0] pINIT_BCD = 4'd0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] loadBcd_i,
  input  logic       step_i,
  input  logic       dn_i,
  output logic [4:0] code_o,
  output logic [3:0] bcd_o,
  output logic       isNine_o,
  output logic       isZero_o,
  output logic       illegal_o,
  output logic       badLoad_o
);

  logic [4:0] code_q, code_d;

  assign code_o    = code_q;
  assign bcd_o     = decode(code_q);
  assign isNine_o  = (bcd_o == 4'd9);
  assign isZero_o  = (bcd_o == 4'd0);
  assign illegal_o = ~isLegal(code_q);
  assign badLoad_o = (loadBcd_i > 4'd9);

  // A scrub beats a step, so an illegal digit never advances on the same edge.
  always_comb begin
    code_d = code_q;
    if (rst_i) begin
      code_d = encode(pINIT_BCD);
    end else if (load_i) begin
      code_d = encode(loadBcd_i);
    end else if (illegal_o) begin
      code_d = cCode0;
    end else if (step_i) begin
      if (dn_i) begin
        code_d = encode((bcd_o == 4'd0) ? 4'd9 : bcd_o - 4'd1);
      end else begin
        code_d = encode((bcd_o == 4'd9) ? 4'd0 : bcd_o + 4'd1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    code_q <= code_d;
  end

endmodule

// File: rtl/grey_decade_chain.sv
// Cascaded unit-distance decade counter: pDIGITS digit cells sharing a
// single-cycle carry/borrow look-ahead, plus registered wrap and error pulses.
module grey_decade_chain
  import grey_pkg::*;
#(
  parameter int unsigned pDIGITS = 4,
  parameter int unsigned pINIT   = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_dn,
  input  logic                   i_load,
  input  logic [4*pDIGITS-1:0]   i_load_bcd,
  output logic [5*pDIGITS-1:0]   o_cnt,
  output logic [4*pDIGITS-1:0]   o_bcd,
  output logic                   o_roll,
  output logic                   o_zero,
  output logic                   o_err
);

  localparam int unsigned cMod     = 10 ** pDIGITS;
  localparam int unsigned cInitMod = pINIT % cMod;

  logic [pDIGITS-1:0] isNine, isZero, illegal, badNib, step;
  logic               roll_q, roll_d, err_q, err_d;

  // Each digit looks at all lower digits directly instead of through a
  // rippled chain, so the whole counter settles within the cycle.
  for (genvar k = 0; k < pDIGITS; k++) begin : genDigit
    localparam int unsigned        cInitDigit = (cInitMod / (10 ** k)) % 10;
    localparam logic [pDIGITS-1:0] cBelow     = pDIGITS'((1 << k) - 1);

    assign step[k] = i_en & (i_dn ? &(isZero | ~cBelow) : &(isNine | ~cBelow));

    grey_digit #(
      .pINIT_BCD(4'(cInitDigit))
    ) uDigit (
      .clk_i    (i_clk),
      .rst_i    (i_rst),
      .load_i   (i_load),
      .loadBcd_i(i_load_bcd[4*k +: 4]),
      .step_i   (step[k]),
      .dn_i     (i_dn),
      .code_o   (o_cnt[5*k +: 5]),
      .bcd_o    (o_bcd[4*k +: 4]),
      .isNine_o (isNine[k]),
      .isZero_o (isZero[k]),
      .illegal_o(illegal[k]),
      .badLoad_o(badNib[k])
    );
  end

  // A wrap only counts when every digit actually steps; a scrubbed digit breaks it.
  always_comb begin
    roll_d = 1'b0;
    err_d  = 1'b0;
    if (!i_rst) begin
      err_d = (i_load & |badNib) | (|illegal);
      if (!i_load && i_en && !(|illegal)) begin
        roll_d = i_dn ? &isZero : &isNine;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    roll_q <= roll_d;
    err_q  <= err_d;
  end

  assign o_roll = roll_q;
  assign o_err  = err_q;
  assign o_zero = (o_bcd == '0);

endmodule

// File: tb/tb_grey_decade_chain.sv
// Scoreboard bench: a 2-digit chain (pINIT=37) checked against a decimal
// model, plus an 8-digit chain for full-width wrap and reset priority.
module tb_grey_decade_chain;

  logic        clk = 1'b0;
  logic        rst2, load2, en2, dn2;
  logic [7:0]  loadBcd2;
  logic [9:0]  cnt2;
  logic [7:0]  bcd2;
  logic        roll2, zero2, err2;

  logic        rst8, load8, en8, dn8;
  logic [31:0] loadBcd8;
  logic [39:0] cnt8;
  logic [31:0] bcd8;
  logic        roll8, zero8, err8;

  int checkCount = 0;
  int errorCount = 0;
  int modelVal   = 0;

  typedef struct {
    string      tag;
    logic [7:0] bcd;
    logic [9:0] cnt;
    logic       roll;
    logic       err;
    logic       zero;
    logic       stepped;
    logic [1:0] flips;
  } expT;

  expT sbQ[$];

  always #5 clk = ~clk;

  grey_decade_chain #(.pDIGITS(2), .pINIT(37)) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_en(en2), .i_dn(dn2), .i_load(load2),
    .i_load_bcd(loadBcd2), .o_cnt(cnt2), .o_bcd(bcd2), .o_roll(roll2),
    .o_zero(zero2), .o_err(err2)
  );

  grey_decade_chain #(.pDIGITS(8), .pINIT(99999999)) dut8 (
    .i_clk(clk), .i_rst(rst8), .i_en(en8), .i_dn(dn8), .i_load(load8),
    .i_load_bcd(loadBcd8), .o_cnt(cnt8), .o_bcd(bcd8), .o_roll(roll8),
    .o_zero(zero8), .o_err(err8)
  );

  function automatic logic [4:0] refCode(input int d);
    case (d)
      0: return 5'b11000;
      1: return 5'b11001;
      2: return 5'b10001;
      3: return 5'b10011;
      4: return 5'b00011;
      5: return 5'b00111;
      6: return 5'b00110;
      7: return 5'b01110;
      8: return 5'b01100;
      default: return 5'b11100;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle on dut2, push the model's expectation, then pop and compare.
  task automatic applyStimulus(input string tag, input logic rst, input logic load,
                               input logic [7:0] bcd, input logic en,
                               input logic dn, input logic forceBad);
    expT        e;
    expT        got;
    int         tens, ones, oldVal;
    logic [9:0] lastCnt;
    @(negedge clk);
    lastCnt  = cnt2;
    rst2     = rst;
    load2    = load;
    loadBcd2 = bcd;
    en2      = en;
    dn2      = dn;
    oldVal   = modelVal;
    e.tag = tag; e.roll = 1'b0; e.err = 1'b0; e.stepped = 1'b0; e.flips = 2'd0;
    if (rst) begin
      modelVal = 37;
    end else if (load) begin
      tens = int'(bcd[7:4]);
      ones = int'(bcd[3:0]);
      if (tens > 9) begin tens = 0; e.err = 1'b1; end
      if (ones > 9) begin ones = 0; e.err = 1'b1; end
      modelVal = tens * 10 + ones;
    end else if (forceBad) begin
      ones = modelVal % 10;
      if (en) ones = dn ? (ones + 9) % 10 : (ones + 1) % 10;
      modelVal = ones;
      e.err    = 1'b1;
    end else if (en) begin
      if (!dn) begin
        e.roll   = (modelVal == 99);
        modelVal = (modelVal + 1) % 100;
      end else begin
        e.roll   = (modelVal == 0);
        modelVal = (modelVal + 99) % 100;
      end
      e.stepped = 1'b1;
      e.flips   = {1'b0, ((oldVal / 10) != (modelVal / 10))} + 2'd0;
    end
    if (forceBad) begin
      force dut2.genDigit[1].uDigit.code_q = 5'b10101;
      #1;
      release dut2.genDigit[1].uDigit.code_q;
    end
    e.bcd  = {4'(modelVal / 10), 4'(modelVal % 10)};
    e.cnt  = {refCode(modelVal / 10), refCode(modelVal % 10)};
    e.zero = (modelVal == 0);
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    got = sbQ.pop_front();
    checkOutput({got.tag, "/bcd"},  64'(bcd2),  64'(got.bcd));
    checkOutput({got.tag, "/cnt"},  64'(cnt2),  64'(got.cnt));
    checkOutput({got.tag, "/roll"}, 64'(roll2), 64'(got.roll));
    checkOutput({got.tag, "/err"},  64'(err2),  64'(got.err));
    checkOutput({got.tag, "/zero"}, 64'(zero2), 64'(got.zero));
    if (got.stepped) begin
      checkOutput({got.tag, "/flip0"}, 64'($countones(cnt2[4:0] ^ lastCnt[4:0])), 64'd1);
      checkOutput({got.tag, "/flip1"}, 64'($countones(cnt2[9:5] ^ lastCnt[9:5])),
                  64'(got.flips));
    end
  endtask

  initial begin
    rst2 = 1'b1; load2 = 1'b0; loadBcd2 = '0; en2 = 1'b0; dn2 = 1'b0;
    rst8 = 1'b1; load8 = 1'b0; loadBcd8 = '0; en8 = 1'b0; dn8 = 1'b0;

    applyStimulus("reset",  1, 0, 8'h00, 0, 0, 0);
    applyStimulus("load98", 0, 1, 8'h98, 0, 0, 0);
    applyStimulus("up99",   0, 0, 8'h00, 1, 0, 0);
    applyStimulus("up00",   0, 0, 8'h00, 1, 0, 0);
    applyStimulus("idle",   0, 0, 8'h00, 0, 0, 0);
    applyStimulus("dn99",   0, 0, 8'h00, 1, 1, 0);
    applyStimulus("dn98",   0, 0, 8'h00, 1, 1, 0);
    applyStimulus("ldBad",  0, 1, 8'h5C, 1, 0, 0);
    applyStimulus("idle2",  0, 0, 8'h00, 0, 0, 0);
    applyStimulus("load99", 0, 1, 8'h99, 0, 0, 0);
    applyStimulus("load00", 0, 1, 8'h00, 0, 0, 0);
    applyStimulus("ld42",   0, 1, 8'h42, 0, 0, 0);
    applyStimulus("scrub",  0, 0, 8'h00, 1, 0, 1);
    applyStimulus("resume", 0, 0, 8'h00, 1, 0, 0);
    applyStimulus("rstLd",  1, 1, 8'h11, 1, 0, 0);
    applyStimulus("relEn",  0, 0, 8'h00, 1, 0, 0);
    applyStimulus("rstEn",  1, 0, 8'h00, 1, 1, 0);
    applyStimulus("relDn",  0, 0, 8'h00, 1, 1, 0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] rb;
      rb = 8'($urandom_range(0, 255));
      applyStimulus("rand", 0, ($urandom_range(0, 7) == 0), rb,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    @(negedge clk);
    rst8 = 1'b1; en8 = 1'b0;
    @(posedge clk); #1;
    checkOutput("d8/reset", 64'(bcd8), 64'h99999999);
    checkOutput("d8/resetRoll", 64'(roll8), 64'd0);
    @(negedge clk);
    rst8 = 1'b1; en8 = 1'b1;
    @(posedge clk); #1;
    checkOutput("d8/rstWins", 64'(bcd8), 64'h99999999);
    checkOutput("d8/rstWinsRoll", 64'(roll8), 64'd0);
    @(negedge clk);
    rst8 = 1'b0; en8 = 1'b1;
    @(posedge clk); #1;
    checkOutput("d8/wrapBcd", 64'(bcd8), 64'd0);
    checkOutput("d8/wrapCnt", 64'(cnt8), 64'({8{5'b11000}}));
    checkOutput("d8/wrapZero", 64'(zero8), 64'd1);
    checkOutput("d8/wrapRoll", 64'(roll8), 64'd1);
    checkOutput("d8/wrapErr", 64'(err8), 64'd0);
    @(negedge clk);
    en8 = 1'b0;
    @(posedge clk); #1;
    checkOutput("d8/rollOnce", 64'(roll8), 64'd0);
    checkOutput("d8/hold", 64'(bcd8), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
